// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file: bus response codes and
// the write-channel state encoding.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wstate_t;

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge for a strobed write: lanes with strb set take the new
// byte, all other lanes keep the old byte.
module axi4_lite_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged
);

  // NOTE: the output gets a default before the loop so every path assigns it;
  // a combinational block that leaves a signal unassigned on some path infers a latch.
  always_comb begin
    merged = old_word;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS DATA_W-bit control/status registers,
// with byte strobes, a per-register read-only mask and SLVERR on bad access.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 8,
  parameter int                  NUM_REGS = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  input  logic [NUM_REGS*DATA_W-1:0] regs_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFFS;

  wstate_t             wstate, wstate_nxt;
  logic                aw_held, w_held;
  logic [IDX_W-1:0]    aw_idx;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  resp_t               bresp_q;
  logic                commit;
  logic                aw_hs, w_hs;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   wr_old, wr_merged;
  logic                wr_hit, wr_ro, wr_ok;

  logic [IDX_W-1:0]    ar_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_hit;

  // Sub-word address bits are ignored by design.
  logic                unused_low_addr;
  assign unused_low_addr = ^{AWADDR[OFFS-1:0], ARADDR[OFFS-1:0]};

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign BVALID = (wstate == W_RESP);
  assign BRESP  = bresp_q;

  // Write FSM: collect AW and W independently, commit once both are held.
  always_comb begin
    wstate_nxt = wstate;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    commit     = 1'b0;
    unique case (wstate)
      W_COLLECT: begin
        AWREADY = !aw_held;
        WREADY  = !w_held;
        if (aw_held && w_held) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) wstate_nxt = W_COLLECT;
      end
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values; this is
  // also what makes a read on the commit edge return the pre-write contents.
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate  <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx  <= AWADDR[ADDR_W-1:OFFS];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= WDATA;
          w_strb <= WSTRB;
        end
      end
    end
  end

  // Write decode: an index matching no register is out of range.
  always_comb begin
    wr_old = '0;
    wr_hit = 1'b0;
    wr_ro  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        wr_hit = 1'b1;
        wr_ro  = RO_MASK[i];
        wr_old = regs[i];
      end
    end
    wr_ok = wr_hit && !wr_ro;
  end

  axi4_lite_strb_merge #(
    .DATA_W (DATA_W)
  ) u_strb_merge (
    .old_word (wr_old),
    .new_word (w_data),
    .strb     (w_strb),
    .merged   (wr_merged)
  );

  // NOTE: the register array is reset because regs_out must read zero after
  // reset; that rules out RAM inference, which is acceptable for a control block.
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_ok && aw_idx == IDX_W'(i)) begin
          regs[i]     <= wr_merged;
          wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_out[i*DATA_W +: DATA_W] = regs[i];
  end

  // Read mux: read-only registers reflect live status inputs.
  assign ar_idx = ARADDR[ADDR_W-1:OFFS];

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = RO_MASK[i] ? regs_in[i*DATA_W +: DATA_W] : regs[i];
      end
    end
  end

  assign ARREADY = !RVALID;

  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= OKAY;
    end else if (RVALID) begin
      if (RREADY) RVALID <= 1'b0;
    end else if (ARVALID) begin
      RVALID <= 1'b1;
      RDATA  <= rd_word;
      RRESP  <= rd_hit ? OKAY : SLVERR;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: write ordering, strobes, bad and
// read-only accesses, backpressure and asynchronous reset.
module tb_axi4_lite_regfile;

  localparam int                  DATA_W   = 32;
  localparam int                  ADDR_W   = 8;
  localparam int                  NUM_REGS = 32;
  localparam logic [NUM_REGS-1:0] RO_MASK  = 32'h0000_0002;

  logic                       clk = 1'b0;
  logic                       ARESETN = 1'b1;
  logic [ADDR_W-1:0]          AWADDR = '0;
  logic                       AWVALID = 1'b0;
  logic                       AWREADY;
  logic [DATA_W-1:0]          WDATA = '0;
  logic [DATA_W/8-1:0]        WSTRB = '0;
  logic                       WVALID = 1'b0;
  logic                       WREADY;
  logic [1:0]                 BRESP;
  logic                       BVALID;
  logic                       BREADY = 1'b0;
  logic [ADDR_W-1:0]          ARADDR = '0;
  logic                       ARVALID = 1'b0;
  logic                       ARREADY;
  logic [DATA_W-1:0]          RDATA;
  logic [1:0]                 RRESP;
  logic                       RVALID;
  logic                       RREADY = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] regs_in = '0;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0]        wr_pulse;

  int checks = 0;
  int errors = 0;

  logic [1:0]                 resp;
  logic [NUM_REGS-1:0]        pulse;
  logic [DATA_W-1:0]          rd;
  logic [1:0]                 rr;
  logic [NUM_REGS*DATA_W-1:0] snap;

  axi4_lite_regfile #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK)
  ) dut (
    .clk      (clk),
    .ARESETN  (ARESETN),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .ARADDR   (ARADDR),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .regs_in  (regs_in),
    .regs_out (regs_out),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with AW and W together; returns BRESP and wr_pulse seen with BVALID.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [3:0] strb, output logic [1:0] r,
                          output logic [NUM_REGS-1:0] p);
    logic got;
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    got = 1'b0; r = 2'b11; p = '0;
    for (int n = 0; n < 10 && !got; n++) begin
      tick();
      if (BVALID) begin got = 1'b1; r = BRESP; p = wr_pulse; end
    end
    checks++;
    if (!got) begin
      $display("FAIL write_timeout addr=%h: BVALID=0, required BVALID=1 within 10 cycles", addr);
      errors++;
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] d,
                         output logic [1:0] r);
    logic got;
    int n;
    ARADDR = addr; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    got = RVALID; n = 0;
    while (!got && n < 10) begin tick(); got = RVALID; n++; end
    checks++;
    if (!got) begin
      $display("FAIL read_timeout addr=%h: RVALID=0, required RVALID=1 within 10 cycles", addr);
      errors++;
    end
    d = RDATA; r = RRESP;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    #2 ARESETN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ARESETN = 1'b1;
    tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      $display("FAIL reset_ready: got %b, required 111", {AWREADY, WREADY, ARREADY}); errors++;
    end
    checks++;
    if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin
      $display("FAIL reset_valid_resp: got %b, required 000000", {BVALID, RVALID, BRESP, RRESP}); errors++;
    end
    checks++;
    if (regs_out !== '0 || wr_pulse !== '0 || RDATA !== '0) begin
      $display("FAIL reset_regs: regs_out/wr_pulse/RDATA nonzero, required all zero"); errors++;
    end
  endtask

  task automatic test_same_cycle();
    AWADDR = 8'h08; AWVALID = 1'b1;
    WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b000) begin
      $display("FAIL same_cycle_held: BVALID/AWREADY/WREADY=%b, required 000", {BVALID, AWREADY, WREADY}); errors++;
    end
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      $display("FAIL same_cycle_bresp: BVALID=%b BRESP=%b, required 1 00", BVALID, BRESP); errors++;
    end
    checks++;
    if (regs_out[2*32 +: 32] !== 32'hDEAD_BEEF) begin
      $display("FAIL same_cycle_reg2: got %h, required deadbeef", regs_out[2*32 +: 32]); errors++;
    end
    checks++;
    if (wr_pulse !== 32'h0000_0004) begin
      $display("FAIL same_cycle_pulse: got %h, required 00000004", wr_pulse); errors++;
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checks++;
    if (wr_pulse !== '0 || BVALID !== 1'b0 || {AWREADY, WREADY} !== 2'b11) begin
      $display("FAIL same_cycle_after: pulse=%h BVALID=%b rdy=%b, required 0 0 11",
               wr_pulse, BVALID, {AWREADY, WREADY}); errors++;
    end
  endtask

  task automatic test_w_first();
    do_write(8'h0C, 32'hAAAA_AAAA, 4'hF, resp, pulse);
    WDATA = 32'h1234_5678; WSTRB = 4'b0011; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b100) begin
      $display("FAIL w_first_held: AWREADY/WREADY/BVALID=%b, required 100", {AWREADY, WREADY, BVALID}); errors++;
    end
    tick();
    tick();
    AWADDR = 8'h0C; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      $display("FAIL w_first_early: BVALID=%b, required 0", BVALID); errors++;
    end
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || wr_pulse !== 32'h0000_0008) begin
      $display("FAIL w_first_resp: BVALID=%b BRESP=%b pulse=%h, required 1 00 00000008",
               BVALID, BRESP, wr_pulse); errors++;
    end
    checks++;
    if (regs_out[3*32 +: 32] !== 32'hAAAA_5678) begin
      $display("FAIL w_first_merge: got %h, required aaaa5678", regs_out[3*32 +: 32]); errors++;
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic test_bad_addr();
    snap = regs_out;
    do_write(8'h80, 32'h0BAD_0BAD, 4'hF, resp, pulse);
    checks++;
    if (resp !== 2'b10 || pulse !== '0) begin
      $display("FAIL bad_write: BRESP=%b pulse=%h, required 10 00000000", resp, pulse); errors++;
    end
    checks++;
    if (regs_out !== snap) begin
      $display("FAIL bad_write_regs: regs_out changed, required unchanged"); errors++;
    end
    do_read(8'h80, rd, rr);
    checks++;
    if (rd !== 32'h0 || rr !== 2'b10) begin
      $display("FAIL bad_read: RDATA=%h RRESP=%b, required 00000000 10", rd, rr); errors++;
    end
    do_write(8'h7C, 32'h7C7C_7C7C, 4'hF, resp, pulse);
    checks++;
    if (resp !== 2'b00 || pulse !== 32'h8000_0000 || regs_out[31*32 +: 32] !== 32'h7C7C_7C7C) begin
      $display("FAIL last_reg: BRESP=%b pulse=%h reg31=%h, required 00 80000000 7c7c7c7c",
               resp, pulse, regs_out[31*32 +: 32]); errors++;
    end
  endtask

  task automatic test_read_only();
    do_write(8'h04, 32'hFFFF_FFFF, 4'hF, resp, pulse);
    checks++;
    if (resp !== 2'b10 || pulse !== '0 || regs_out[1*32 +: 32] !== 32'h0) begin
      $display("FAIL ro_write: BRESP=%b pulse=%h reg1=%h, required 10 00000000 00000000",
               resp, pulse, regs_out[1*32 +: 32]); errors++;
    end
    do_read(8'h04, rd, rr);
    checks++;
    if (rd !== 32'hCAFE_0001 || rr !== 2'b00) begin
      $display("FAIL ro_read: RDATA=%h RRESP=%b, required cafe0001 00", rd, rr); errors++;
    end
    do_write(8'h08, 32'h1212_1212, 4'h0, resp, pulse);
    checks++;
    if (resp !== 2'b00 || pulse !== 32'h0000_0004 || regs_out[2*32 +: 32] !== 32'hDEAD_BEEF) begin
      $display("FAIL zero_strb: BRESP=%b pulse=%h reg2=%h, required 00 00000004 deadbeef",
               resp, pulse, regs_out[2*32 +: 32]); errors++;
    end
    do_read(8'h0B, rd, rr);
    checks++;
    if (rd !== 32'hDEAD_BEEF || rr !== 2'b00) begin
      $display("FAIL unaligned_read: RDATA=%h RRESP=%b, required deadbeef 00", rd, rr); errors++;
    end
  endtask

  task automatic test_backpressure();
    AWADDR = 8'h14; AWVALID = 1'b1;
    WDATA = 32'h55AA_55AA; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 8'h08; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 8'h04;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
        $display("FAIL stall_write c=%0d: BVALID/BRESP/AWREADY/WREADY=%b, required 10000",
                 c, {BVALID, BRESP, AWREADY, WREADY}); errors++;
      end
      checks++;
      if ({RVALID, ARREADY, RRESP} !== 4'b1000 || RDATA !== 32'hDEAD_BEEF) begin
        $display("FAIL stall_read c=%0d: RVALID/ARREADY/RRESP=%b RDATA=%h, required 1000 deadbeef",
                 c, {RVALID, ARREADY, RRESP}, RDATA); errors++;
      end
      tick();
    end
    ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    checks++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      $display("FAIL stall_release: BVALID/RVALID/AWREADY/WREADY/ARREADY=%b, required 00111",
               {BVALID, RVALID, AWREADY, WREADY, ARREADY}); errors++;
    end
    checks++;
    if (regs_out[5*32 +: 32] !== 32'h55AA_55AA) begin
      $display("FAIL stall_reg5: got %h, required 55aa55aa", regs_out[5*32 +: 32]); errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_write(8'h18, 32'h1111_1111, 4'hF, resp, pulse);
    AWADDR = 8'h18; AWVALID = 1'b1;
    WDATA = 32'h2222_2222; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 8'h18; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    checks++;
    if ({BVALID, RVALID} !== 2'b11 || RDATA !== 32'h1111_1111) begin
      $display("FAIL read_on_commit: BVALID/RVALID=%b RDATA=%h, required 11 11111111",
               {BVALID, RVALID}, RDATA); errors++;
    end
    checks++;
    if (regs_out[6*32 +: 32] !== 32'h2222_2222) begin
      $display("FAIL commit_reg6: got %h, required 22222222", regs_out[6*32 +: 32]); errors++;
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(8'h18, rd, rr);
    checks++;
    if (rd !== 32'h2222_2222 || rr !== 2'b00) begin
      $display("FAIL read_after_commit: RDATA=%h RRESP=%b, required 22222222 00", rd, rr); errors++;
    end
  endtask

  task automatic test_async_reset();
    AWADDR = 8'h08; AWVALID = 1'b1;
    WDATA = 32'h0F0F_0F0F; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 8'h08; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tick();
    checks++;
    if ({BVALID, RVALID} !== 2'b11) begin
      $display("FAIL pre_reset_valid: BVALID/RVALID=%b, required 11", {BVALID, RVALID}); errors++;
    end
    #3 ARESETN = 1'b0;
    #1;
    checks++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      $display("FAIL async_reset_hs: BVALID/RVALID/AWREADY/WREADY/ARREADY=%b, required 00111",
               {BVALID, RVALID, AWREADY, WREADY, ARREADY}); errors++;
    end
    checks++;
    if (regs_out !== '0 || wr_pulse !== '0) begin
      $display("FAIL async_reset_regs: regs_out/wr_pulse nonzero, required all zero"); errors++;
    end
    @(posedge clk);
    #1;
    ARESETN = 1'b1;
    tick();
    do_read(8'h08, rd, rr);
    checks++;
    if (rd !== 32'h0 || rr !== 2'b00) begin
      $display("FAIL post_reset_read: RDATA=%h RRESP=%b, required 00000000 00", rd, rr); errors++;
    end
  endtask

  initial begin
    regs_in[1*32 +: 32] = 32'hCAFE_0001;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_bad_addr();
    test_read_only();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
